// File: rtl/cv32e40x_pkg.sv
// Shared MPU types: response fault status, controller state and PMA regions.
// Optional CV32E40X_MPU_MEMTYPE_EN exports PMA memory attributes on the bus.
package cv32e40x_pkg;

    typedef enum logic [1:0] {
        MPU_OK                 = 2'b00,
        MPU_INSTR_ACCESS_FAULT = 2'b01,
        MPU_LOAD_ACCESS_FAULT  = 2'b10,
        MPU_STORE_ACCESS_FAULT = 2'b11
    } mpu_status_e;

    typedef enum logic {
        MPU_IDLE     = 1'b0,
        MPU_ERR_WAIT = 1'b1
    } mpu_state_e;

    // Byte address range, both bounds inclusive
    typedef struct packed {
        logic [31:0] addr_low;
        logic [31:0] addr_high;
        logic        main;
        logic        bufferable;
        logic        cacheable;
        logic        atomic;
    } pma_region_t;

    localparam pma_region_t PMA_R_DEFAULT = '{
        addr_low:   32'h0000_0000,
        addr_high:  32'hFFFF_FFFF,
        main:       1'b1,
        bufferable: 1'b0,
        cacheable:  1'b0,
        atomic:     1'b1
    };

    function automatic mpu_status_e mpu_fault(input logic instr, input logic we);
        if (instr) begin
            return MPU_INSTR_ACCESS_FAULT;
        end
        return we ? MPU_STORE_ACCESS_FAULT : MPU_LOAD_ACCESS_FAULT;
    endfunction

endpackage

// File: rtl/cv32e40x_pma.sv
// PMA lookup: lowest-index matching region wins; no match means
// non-main, non-atomic, uncached I/O space.
module cv32e40x_pma
    import cv32e40x_pkg::*;
#(
    parameter int          PMA_NUM_REGIONS = 1,
    parameter pma_region_t PMA_CFG [0:PMA_NUM_REGIONS-1] = '{PMA_R_DEFAULT}
) (
    input  logic [31:0] trans_addr_i,
    input  logic        instr_fetch_i,
    input  logic        speculative_access_i,
    input  logic        atomic_access_i,
    output logic        pma_blocked_o,
    output logic        pma_bufferable_o,
    output logic        pma_cacheable_o
);

    logic main_s;
    logic atomic_s;

    always_comb begin
        main_s           = 1'b0;
        atomic_s         = 1'b0;
        pma_bufferable_o = 1'b0;
        pma_cacheable_o  = 1'b0;
        for (int i = PMA_NUM_REGIONS - 1; i >= 0; i--) begin
            if (trans_addr_i >= PMA_CFG[i].addr_low &&
                trans_addr_i <= PMA_CFG[i].addr_high) begin
                main_s           = PMA_CFG[i].main;
                atomic_s         = PMA_CFG[i].atomic;
                pma_bufferable_o = PMA_CFG[i].bufferable;
                pma_cacheable_o  = PMA_CFG[i].cacheable;
            end
        end
    end

    // I/O space is never fetched from nor touched speculatively
    assign pma_blocked_o = (instr_fetch_i && !main_s) ||
                           (speculative_access_i && !main_s) ||
                           (atomic_access_i && !atomic_s);

endmodule

// File: rtl/cv32e40x_mpu_ctrl.sv
// MPU controller between requester and OBI: PMA blocking, ordered synthetic
// fault responses, outstanding tracking. Option: CV32E40X_MPU_MEMTYPE_EN.
module cv32e40x_mpu_ctrl
    import cv32e40x_pkg::*;
#(
    parameter int          IF_STAGE        = 1,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          PMA_NUM_REGIONS = 1,
    parameter pma_region_t PMA_CFG [0:PMA_NUM_REGIONS-1] = '{PMA_R_DEFAULT}
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        speculative_access_i,
    input  logic        atomic_access_i,
    input  logic        core_trans_valid_i,
    output logic        core_trans_ready_o,
    input  logic [31:0] core_trans_addr_i,
    input  logic        core_trans_we_i,
    output logic        core_resp_valid_o,
    output logic        core_resp_err_o,
    output logic [1:0]  core_resp_mpu_status_o,
    output logic        bus_trans_valid_o,
    input  logic        bus_trans_ready_i,
    output logic [31:0] bus_trans_addr_o,
    output logic        bus_trans_we_o,
    output logic [1:0]  bus_trans_memtype_o,
    input  logic        bus_resp_valid_i,
    input  logic        bus_resp_err_i
);

    localparam int              CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    mpu_state_e       state_q, state_d;
    mpu_status_e      status_q, status_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic pma_blocked;
    logic pma_bufferable;
    logic pma_cacheable;
    logic bus_issue;
    logic err_resp;

    cv32e40x_pma #(
        .PMA_NUM_REGIONS (PMA_NUM_REGIONS),
        .PMA_CFG         (PMA_CFG)
    ) pma_i (
        .trans_addr_i         (core_trans_addr_i),
        .instr_fetch_i        (IF_STAGE != 0),
        .speculative_access_i (speculative_access_i),
        .atomic_access_i      (atomic_access_i),
        .pma_blocked_o        (pma_blocked),
        .pma_bufferable_o     (pma_bufferable),
        .pma_cacheable_o      (pma_cacheable)
    );

    assign bus_trans_addr_o = core_trans_addr_i;
    assign bus_trans_we_o   = core_trans_we_i;

`ifdef CV32E40X_MPU_MEMTYPE_EN
    assign bus_trans_memtype_o = {pma_cacheable, pma_bufferable};
`else
    logic unused_memtype;
    assign unused_memtype      = pma_cacheable ^ pma_bufferable;
    assign bus_trans_memtype_o = 2'b00;
`endif

    always_comb begin
        state_d            = state_q;
        status_d           = status_q;
        bus_trans_valid_o  = 1'b0;
        core_trans_ready_o = 1'b0;
        unique case (state_q)
            MPU_IDLE: begin
                if (pma_blocked) begin
                    core_trans_ready_o = 1'b1;
                    if (core_trans_valid_i) begin
                        status_d = mpu_fault(IF_STAGE != 0, core_trans_we_i);
                        state_d  = MPU_ERR_WAIT;
                    end
                end else if (cnt_q != CNT_MAX) begin
                    bus_trans_valid_o  = core_trans_valid_i;
                    core_trans_ready_o = bus_trans_ready_i;
                end
            end
            MPU_ERR_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = MPU_IDLE;
                end
            end
            default: state_d = MPU_IDLE;
        endcase
    end

    assign bus_issue = bus_trans_valid_o && bus_trans_ready_i;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({bus_issue, bus_resp_valid_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= MPU_IDLE;
            status_q <= MPU_OK;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
        end
    end

    // Synthetic response only once every earlier bus response has drained
    assign err_resp = (state_q == MPU_ERR_WAIT) && (cnt_q == '0);

    assign core_resp_valid_o      = bus_resp_valid_i || err_resp;
    assign core_resp_err_o        = bus_resp_valid_i && bus_resp_err_i;
    assign core_resp_mpu_status_o = bus_resp_valid_i ? MPU_OK :
                                    err_resp         ? status_q : MPU_OK;

    a_no_underflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        bus_resp_valid_i |-> cnt_q != '0
    );

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        cnt_q <= CNT_MAX
    );

endmodule

// File: tb/tb_cv32e40x_mpu_ctrl.sv
// Directed bench: data-side (MAX_OUTSTANDING=2) and instruction-side MPU
// controllers exercised with hand-computed expectations.
module tb_cv32e40x_mpu_ctrl;
    import cv32e40x_pkg::*;

    localparam pma_region_t CFG [0:1] = '{
        '{addr_low: 32'h0000_0000, addr_high: 32'h0000_FFFF,
          main: 1'b1, bufferable: 1'b1, cacheable: 1'b1, atomic: 1'b1},
        '{addr_low: 32'h1000_0000, addr_high: 32'h1000_0FFF,
          main: 1'b0, bufferable: 1'b0, cacheable: 1'b0, atomic: 1'b0}
    };

`ifdef CV32E40X_MPU_MEMTYPE_EN
    localparam logic [1:0] MT_MAIN = 2'b11;
`else
    localparam logic [1:0] MT_MAIN = 2'b00;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        d_spec, d_atom, d_valid, d_ready, d_we;
    logic [31:0] d_addr, d_baddr;
    logic        d_rvalid, d_rerr, d_bvalid, d_bready, d_bwe;
    logic [1:0]  d_status, d_memtype;
    logic        d_brvalid, d_brerr;

    logic        i_valid, i_ready;
    logic [31:0] i_addr, i_baddr;
    logic        i_rvalid, i_rerr, i_bvalid, i_bready, i_bwe;
    logic [1:0]  i_status, i_memtype;
    logic        i_brvalid, i_brerr;

    cv32e40x_mpu_ctrl #(
        .IF_STAGE(0), .MAX_OUTSTANDING(2),
        .PMA_NUM_REGIONS(2), .PMA_CFG(CFG)
    ) dut_d (
        .clk(clk), .rst_n(rst_n),
        .speculative_access_i(d_spec), .atomic_access_i(d_atom),
        .core_trans_valid_i(d_valid), .core_trans_ready_o(d_ready),
        .core_trans_addr_i(d_addr), .core_trans_we_i(d_we),
        .core_resp_valid_o(d_rvalid), .core_resp_err_o(d_rerr),
        .core_resp_mpu_status_o(d_status),
        .bus_trans_valid_o(d_bvalid), .bus_trans_ready_i(d_bready),
        .bus_trans_addr_o(d_baddr), .bus_trans_we_o(d_bwe),
        .bus_trans_memtype_o(d_memtype),
        .bus_resp_valid_i(d_brvalid), .bus_resp_err_i(d_brerr)
    );

    cv32e40x_mpu_ctrl #(
        .IF_STAGE(1), .MAX_OUTSTANDING(2),
        .PMA_NUM_REGIONS(2), .PMA_CFG(CFG)
    ) dut_i (
        .clk(clk), .rst_n(rst_n),
        .speculative_access_i(1'b0), .atomic_access_i(1'b0),
        .core_trans_valid_i(i_valid), .core_trans_ready_o(i_ready),
        .core_trans_addr_i(i_addr), .core_trans_we_i(1'b0),
        .core_resp_valid_o(i_rvalid), .core_resp_err_o(i_rerr),
        .core_resp_mpu_status_o(i_status),
        .bus_trans_valid_o(i_bvalid), .bus_trans_ready_i(i_bready),
        .bus_trans_addr_o(i_baddr), .bus_trans_we_o(i_bwe),
        .bus_trans_memtype_o(i_memtype),
        .bus_resp_valid_i(i_brvalid), .bus_resp_err_i(i_brerr)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        d_spec = 0; d_atom = 0; d_valid = 0; d_we = 0; d_addr = '0;
        d_bready = 0; d_brvalid = 0; d_brerr = 0;
        i_valid = 0; i_addr = '0; i_bready = 0; i_brvalid = 0; i_brerr = 0;
        tick();
        tick();
        check("rst_state", dut_d.state_q, MPU_IDLE);
        check("rst_cnt", dut_d.cnt_q, 0);
        check("rst_status", dut_d.status_q, MPU_OK);
        check("rst_rvalid", d_rvalid, 0);
        rst_n = 1'b1;

        // allowed load, immediate bus ready
        d_valid = 1; d_addr = 32'h0000_1000; d_bready = 1;
        settle();
        check("ld_bvalid", d_bvalid, 1);
        check("ld_ready", d_ready, 1);
        check("ld_baddr", d_baddr, 32'h0000_1000);
        check("ld_memtype", d_memtype, MT_MAIN);
        tick();
        d_valid = 0;
        check("ld_cnt1", dut_d.cnt_q, 1);
        d_brvalid = 1;
        settle();
        check("ld_rvalid", d_rvalid, 1);
        check("ld_rstatus", d_status, MPU_OK);
        check("ld_rerr", d_rerr, 0);
        tick();
        d_brvalid = 0;
        check("ld_cnt0", dut_d.cnt_q, 0);

        // blocked store (atomic to non-atomic I/O)
        d_valid = 1; d_addr = 32'h2000_0000; d_we = 1; d_atom = 1;
        settle();
        check("st_ready", d_ready, 1);
        check("st_bvalid", d_bvalid, 0);
        check("st_rvalid0", d_rvalid, 0);
        tick();
        d_valid = 0; d_we = 0; d_atom = 0;
        settle();
        check("st_rvalid", d_rvalid, 1);
        check("st_status", d_status, MPU_STORE_ACCESS_FAULT);
        check("st_err", d_rerr, 0);
        tick();
        check("st_done", d_rvalid, 0);
        check("st_idle", dut_d.state_q, MPU_IDLE);

        // two loads outstanding then speculative load to I/O
        d_valid = 1; d_addr = 32'h0000_0100;
        tick();
        d_addr = 32'h0000_0104;
        tick();
        d_addr = 32'h1000_0000; d_spec = 1;
        settle();
        check("ord_ready", d_ready, 1);
        check("ord_bvalid", d_bvalid, 0);
        tick();
        d_valid = 0; d_spec = 0;
        settle();
        check("ord_wait", d_rvalid, 0);
        d_brvalid = 1;
        settle();
        check("ord_r1", d_rvalid, 1);
        check("ord_s1", d_status, MPU_OK);
        tick();
        check("ord_r2", d_rvalid, 1);
        check("ord_s2", d_status, MPU_OK);
        tick();
        d_brvalid = 0;
        settle();
        check("ord_syn", d_rvalid, 1);
        check("ord_syn_st", d_status, MPU_LOAD_ACCESS_FAULT);
        check("ord_syn_err", d_rerr, 0);
        tick();
        check("ord_done", d_rvalid, 0);

        // throttle at MAX_OUTSTANDING
        d_valid = 1; d_addr = 32'h0000_0200;
        tick();
        d_addr = 32'h0000_0204;
        tick();
        d_addr = 32'h0000_0208;
        settle();
        check("thr_bvalid", d_bvalid, 0);
        check("thr_ready", d_ready, 0);
        tick();
        check("thr_hold", d_bvalid, 0);
        d_brvalid = 1;
        settle();
        check("thr_same", d_bvalid, 0);
        check("thr_same_rdy", d_ready, 0);
        tick();
        d_brvalid = 0;
        settle();
        check("thr_lift", d_bvalid, 1);
        check("thr_lift_rdy", d_ready, 1);
        tick();
        d_valid = 0;
        check("thr_cnt2", dut_d.cnt_q, 2);
        d_brvalid = 1;
        tick();
        tick();
        d_brvalid = 0;
        check("thr_cnt0", dut_d.cnt_q, 0);

        // non-speculative load to I/O is allowed
        d_valid = 1; d_addr = 32'h1000_0010;
        settle();
        check("io_bvalid", d_bvalid, 1);
        check("io_memtype", d_memtype, 2'b00);
        tick();
        d_valid = 0; d_brvalid = 1;
        tick();
        d_brvalid = 0;

        // reset while waiting with one outstanding
        d_valid = 1; d_addr = 32'h0000_0300;
        tick();
        d_addr = 32'h2000_0000; d_we = 1; d_atom = 1;
        tick();
        d_valid = 0; d_we = 0; d_atom = 0;
        check("rw_state", dut_d.state_q, MPU_ERR_WAIT);
        check("rw_cnt", dut_d.cnt_q, 1);
        check("rw_rvalid", d_rvalid, 0);
        rst_n = 0;
        tick();
        rst_n = 1;
        check("rw_idle", dut_d.state_q, MPU_IDLE);
        check("rw_cnt0", dut_d.cnt_q, 0);
        check("rw_status", dut_d.status_q, MPU_OK);
        for (int k = 0; k < 3; k++) begin
            check("rw_nosyn", d_rvalid, 0);
            tick();
        end

        // instruction side
        i_valid = 1; i_addr = 32'h1000_0000; i_bready = 1;
        settle();
        check("if_ready", i_ready, 1);
        check("if_bvalid", i_bvalid, 0);
        tick();
        i_valid = 0;
        settle();
        check("if_rvalid", i_rvalid, 1);
        check("if_status", i_status, MPU_INSTR_ACCESS_FAULT);
        check("if_err0", i_rerr, 0);
        tick();
        i_valid = 1; i_addr = 32'h0000_0080;
        settle();
        check("if_ok_bvalid", i_bvalid, 1);
        tick();
        i_valid = 0; i_brvalid = 1; i_brerr = 1;
        settle();
        check("if_berr_v", i_rvalid, 1);
        check("if_berr_e", i_rerr, 1);
        check("if_berr_s", i_status, MPU_OK);
        tick();
        i_brvalid = 0; i_brerr = 0;
        check("if_cnt0", dut_i.cnt_q, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
